// File: rtl/line_sensor_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : line_sensor_reader
//  Purpose  : Charges three RC reflectance sensors, times their discharge and
//             thresholds the result into a registered {front, left, right} vector.
//  Revision : 1.0 - initial release
// ============================================================================
module line_sensor_reader #(
    parameter int CHARGE_CYC  = 100,
    parameter int TIMEOUT_CYC = 2500,
    parameter int CNT_W       = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] threshold,
    input  logic [2:0] sens_in,
    output logic [2:0] sens_out,
    output logic [2:0] sens_oe,
    output logic [2:0] sensors,
    output logic       valid,
    output logic       timeout,
    output logic       busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CHARGE  = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int               C_CCW         = (CHARGE_CYC > 2) ? $clog2(CHARGE_CYC) : 1;
    localparam logic [C_CCW-1:0] C_CHARGE_LAST = C_CCW'(CHARGE_CYC - 1);
    localparam logic [C_CCW-1:0] C_CCNT_ONE    = C_CCW'(1);
    localparam logic [CNT_W-1:0] C_MEAS_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] C_MCNT_ONE    = CNT_W'(1);
    localparam int               C_CMP_W       = (CNT_W > 12) ? CNT_W : 12;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [C_CCW-1:0] r_ccnt;
    logic [CNT_W-1:0] r_mcnt;
    logic [2:0]       r_done;
    logic [CNT_W-1:0] r_t [3];
    logic [7:0]       r_thr;
    logic [2:0]       r_sensors;
    logic             r_timeout;

    logic [2:0]         w_hit;
    logic [2:0]         w_done_nxt;
    logic [2:0]         w_tofill;
    logic [2:0]         w_sens_nxt;
    logic               w_last;
    logic               w_meas_exit;
    logic [CNT_W-1:0]   w_t_nxt [3];
    logic [C_CMP_W-1:0] w_cmp_thr;

    // A channel latches on its first low sample; the window ends when all have
    // latched or the counter reaches its last value, and any straggler is filled.
    assign w_last      = (r_mcnt == C_MEAS_LAST);
    assign w_done_nxt  = r_done | w_hit;
    assign w_meas_exit = (w_done_nxt == 3'b111) || w_last;
    assign w_cmp_thr   = C_CMP_W'({r_thr, 4'b0000});

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_ch
            assign w_hit[g]      = ~r_sync2[g] & ~r_done[g];
            assign w_tofill[g]   = w_last & ~w_done_nxt[g];
            assign w_t_nxt[g]    = w_hit[g]    ? r_mcnt        :
                                   w_tofill[g] ? C_TIMEOUT_VAL : r_t[g];
            assign w_sens_nxt[g] = (C_CMP_W'(w_t_nxt[g]) > w_cmp_thr);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (enable) w_next_state = S_CHARGE;
            S_CHARGE:  if (r_ccnt == C_CHARGE_LAST) w_next_state = S_MEASURE;
            S_MEASURE: if (w_meas_exit) w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Pins are a pure decode of the state register, so reset releases them at once.
    always_comb begin
        sens_oe  = (r_state == S_CHARGE) ? 3'b111 : 3'b000;
        sens_out = (r_state == S_CHARGE) ? 3'b111 : 3'b000;
        busy     = (r_state != S_IDLE);
        valid    = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 3'b000;
            r_sync2   <= 3'b000;
            r_ccnt    <= '0;
            r_mcnt    <= '0;
            r_done    <= 3'b000;
            r_thr     <= 8'd0;
            r_sensors <= 3'b000;
            r_timeout <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_t[i] <= '0;
            end
        end else begin
            r_sync1 <= sens_in;
            r_sync2 <= r_sync1;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_thr  <= threshold;
                        r_ccnt <= '0;
                    end
                end
                S_CHARGE: begin
                    r_ccnt <= r_ccnt + C_CCNT_ONE;
                    r_mcnt <= '0;
                    r_done <= 3'b000;
                end
                S_MEASURE: begin
                    r_mcnt <= r_mcnt + C_MCNT_ONE;
                    r_done <= w_done_nxt;
                    for (int i = 0; i < 3; i++) begin
                        r_t[i] <= w_t_nxt[i];
                    end
                    // Results land with the DONE entry so they are current while valid is high.
                    if (w_meas_exit) begin
                        r_sensors <= w_sens_nxt;
                        r_timeout <= |w_tofill;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sensors = r_sensors;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_line_sensor_reader.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for line_sensor_reader: RC pin model, scan-level reference model and
// per-cycle comparison, plus directed literal checks.
module tb_line_sensor_reader;

    localparam int CHARGE = 4;
    localparam int TO     = 64;
    localparam int CW     = 8;
    localparam int NEVER  = 1000;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       enable    = 1'b1;
    logic [7:0] threshold = 8'd2;
    logic [2:0] sens_in   = 3'b111;
    logic [2:0] sens_out;
    logic [2:0] sens_oe;
    logic [2:0] sensors;
    logic       valid;
    logic       timeout;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_count = 0;

    // d[i]: cycles after pin release until the pin reads low; index 2=front
    int d [3] = '{NEVER, NEVER, NEVER};
    int pcnt [3] = '{0, 0, 0};

    always #5 clk = ~clk;

    line_sensor_reader #(
        .CHARGE_CYC  (CHARGE),
        .TIMEOUT_CYC (TO),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .threshold (threshold),
        .sens_in   (sens_in),
        .sens_out  (sens_out),
        .sens_oe   (sens_oe),
        .sensors   (sensors),
        .valid     (valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // RC pin: driven while enabled, then falls low d[i] cycles after release.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (sens_oe[i]) begin
                pcnt[i] = 0;
                sens_in[i] = sens_out[i];
            end else begin
                if (pcnt[i] >= d[i]) sens_in[i] = 1'b0;
                pcnt[i]++;
            end
        end
    end

    // Scan-level prediction: latched time is the pin delay plus the two
    // synchronizer cycles, clipped to the timeout value.
    function automatic void predict(input logic [7:0] thr, output int len,
                                    output logic [2:0] s, output logic to);
        int t;
        int mx;
        bit all_done;
        mx = 0;
        all_done = 1'b1;
        s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            t = d[i] + 2;
            if (t > TO - 1) begin
                t = TO;
                all_done = 1'b0;
            end else if (t > mx) begin
                mx = t;
            end
            s[i] = (t > int'(thr) * 16);
        end
        len = CHARGE + (all_done ? mx + 1 : TO) + 1;
        to  = !all_done;
    endfunction

    bit         m_in_scan   = 1'b0;
    int         m_cyc       = 0;
    int         m_len       = 0;
    logic [2:0] m_sens      = 3'b000;
    logic [2:0] m_sens_pend = 3'b000;
    logic       m_to        = 1'b0;
    logic       m_to_pend   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_scan = 1'b0;
            m_cyc     = 0;
            m_sens    = 3'b000;
            m_to      = 1'b0;
        end else if (m_in_scan) begin
            if (m_cyc == m_len - 1) begin
                m_in_scan = 1'b0;
            end else begin
                m_cyc++;
                if (m_cyc == m_len - 1) begin
                    m_sens = m_sens_pend;
                    m_to   = m_to_pend;
                end
            end
        end else if (enable) begin
            m_in_scan = 1'b1;
            m_cyc     = 0;
            predict(threshold, m_len, m_sens_pend, m_to_pend);
        end
    end

    always @(negedge clk) begin
        logic [2:0] exp_oe;
        exp_oe = (m_in_scan && m_cyc < CHARGE) ? 3'b111 : 3'b000;
        check("busy", busy, m_in_scan);
        check("sens_oe", sens_oe, exp_oe);
        check("sens_out", sens_out, exp_oe);
        check("valid", valid, (m_in_scan && m_cyc == m_len - 1));
        check("sensors", sensors, m_sens);
        check("timeout", timeout, m_to);
        if (valid === 1'b1) valid_count++;
    end

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (valid !== 1'b1) check({name, "_valid_wait"}, valid, 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check({name, "_idle_wait"}, busy, 0);
    endtask

    task automatic run_scan(input string name, input int df, input int dl, input int dr,
                            input logic [7:0] thr, input logic [7:0] thr_after,
                            input logic [2:0] exp_s, input logic exp_to, input int exp_len);
        int start;
        wait_idle(name);
        d[2] = df; d[1] = dl; d[0] = dr;
        threshold = thr;
        enable = 1'b1;
        @(negedge clk);
        start = cyc;
        enable = 1'b0;
        threshold = thr_after;
        wait_valid(name);
        check({name, "_sensors"}, sensors, exp_s);
        check({name, "_timeout"}, timeout, exp_to);
        check({name, "_len"}, cyc - start + 1, exp_len);
    endtask

    initial begin
        int oe_cnt;
        int first;
        int vc;
        int v1, v2, v3;

        // Reset held with enable high and charged pins
        repeat (3) @(negedge clk);
        check("rst_oe", sens_oe, 3'b000);
        check("rst_sensors", sensors, 3'b000);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        rst_n = 1'b1;
        oe_cnt = 0;
        first = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) enable = 1'b0;
            if (sens_oe === 3'b111) begin
                oe_cnt++;
                if (first < 0) first = k;
            end
        end
        check("rel_oe_first", first, 0);
        check("rel_oe_cycles", oe_cnt, CHARGE);
        wait_valid("first");
        check("first_sensors", sensors, 3'b111);
        check("first_timeout", timeout, 1'b1);

        // latched t = delay + 2
        run_scan("mixed",    8,     48,    18,    8'd2, 8'd2, 3'b010, 1'b0, 56);
        run_scan("tmo",      3,     3,     NEVER, 8'd2, 8'd2, 3'b001, 1'b1, 69);
        run_scan("boundary", 30,    31,    8,     8'd2, 8'd2, 3'b010, 1'b0, 39);
        run_scan("last_cnt", 61,    61,    61,    8'd2, 8'd2, 3'b111, 1'b0, 69);

        // Abort in MEASURE at mcnt=20 (scan cycle 24)
        wait_idle("abort_m");
        d = '{NEVER, NEVER, NEVER};
        vc = valid_count;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (24) @(negedge clk);
        check("abort_m_busy_before", busy, 1'b1);
        check("abort_m_sens_before", sensors, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        check("abort_m_oe", sens_oe, 3'b000);
        check("abort_m_busy", busy, 1'b0);
        check("abort_m_sensors", sensors, 3'b000);
        check("abort_m_valid", valid, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Abort in CHARGE
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_c_oe_before", sens_oe, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        check("abort_c_oe", sens_oe, 3'b000);
        check("abort_c_out", sens_out, 3'b000);
        check("abort_c_busy", busy, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_no_valid", valid_count, vc);

        run_scan("post_abort", 8,     48,    18,    8'd2,  8'd2,  3'b010, 1'b0, 56);
        run_scan("thr_huge",   NEVER, NEVER, NEVER, 8'hFF, 8'hFF, 3'b000, 1'b1, 69);
        run_scan("thr_hold",   8,     8,     8,     8'd0,  8'hFF, 3'b111, 1'b0, 16);

        // Continuous scanning, t=8 on every channel
        wait_idle("cont");
        d = '{6, 6, 6};
        threshold = 8'd2;
        enable = 1'b1;
        wait_valid("cont1");
        v1 = cyc;
        check("cont1_sensors", sensors, 3'b000);
        @(negedge clk);
        wait_valid("cont2");
        v2 = cyc;
        check("cont2_sensors", sensors, 3'b000);
        @(negedge clk);
        wait_valid("cont3");
        v3 = cyc;
        enable = 1'b0;
        check("cont3_sensors", sensors, 3'b000);
        check("cont_gap12", v2 - v1, 15);
        check("cont_gap23", v3 - v2, 15);
        repeat (20) @(negedge clk);
        check("cont_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
